// File: rtl/mem_pkg.sv
// Shared definitions for the word-array controller: FSM state encodings and read/write bus polarity.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package mem_pkg;

    // Controller phases; VERIFY is only entered when write read-back is compiled in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        VERIFY = 3'd3,
        RESP   = 3'd4
    } mem_state_t;

    // Polarity of the word_rw strobe seen by the array.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_addr_dec.sv
// Word address to one-hot select decoder with a global enable; all-zero when disabled.
// Latency: combinational.
// Backpressure: none; the select follows en/addr directly.
module mem_addr_dec #(
    parameter int ADDR_W = 4
) (
    input  logic                     en,
    input  logic [ADDR_W-1:0]        addr,
    output logic [(1<<ADDR_W)-1:0]   sel
);

    // Every address maps to exactly one bit, so at most one bit is ever high.
    always_comb begin
        sel = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            if (en && (addr == ADDR_W'(i))) begin
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Single-request controller for a 4-bit word array: setup, timed access, optional write read-back (MEM_CTRL_READBACK_EN).
// Latency: ACCESS_CYC+2 cycles from accept to response; 2*ACCESS_CYC+3 for writes with read-back enabled.
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int ACCESS_CYC = 2    // 1..15, fits the 4-bit phase counter
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [3:0]               req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [3:0]               rsp_rdata,
    output logic                     rsp_err,
    output logic [(1<<ADDR_W)-1:0]   word_sel,
    output logic                     word_rw,
    output logic [3:0]               word_din,
    input  logic [3:0]               word_dout
);

    localparam logic [3:0] ACC_LAST = 4'(ACCESS_CYC - 1);
`ifdef MEM_CTRL_READBACK_EN
    // VERIFY count 0 is the select-dropped turnaround, 1..ACCESS_CYC are the read cycles.
    localparam logic [3:0] VFY_LAST = 4'(ACCESS_CYC);
`endif

    mem_state_t         state_q;
    mem_state_t         state_nxt;
    logic [3:0]         cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               wr_q;
    logic               rw_q;
    logic [3:0]         din_q;
    logic [3:0]         rdata_q;
    logic               sel_en;
    logic               acc_last;
    logic               accept;
`ifdef MEM_CTRL_READBACK_EN
    logic               err_q;
    logic               vfy_last;
`endif

    assign accept = req_valid & req_ready;

    // State register; reset aborts any operation without producing a response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state decode plus handshake and select-enable outputs.
    always_comb begin
        state_nxt = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        sel_en    = 1'b0;
        acc_last  = 1'b0;
`ifdef MEM_CTRL_READBACK_EN
        vfy_last  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                sel_en = 1'b1;
                if (cnt_q == ACC_LAST) begin
                    acc_last = 1'b1;
`ifdef MEM_CTRL_READBACK_EN
                    state_nxt = wr_q ? VERIFY : RESP;
`else
                    state_nxt = RESP;
`endif
                end
            end
`ifdef MEM_CTRL_READBACK_EN
            VERIFY: begin
                sel_en = (cnt_q != 4'd0);
                if (cnt_q == VFY_LAST) begin
                    vfy_last  = 1'b1;
                    state_nxt = RESP;
                end
            end
`endif
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Phase counter: restarts on every state change, advances inside the timed phases.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else if (state_nxt != state_q) begin
            cnt_q <= 4'd0;
        end else if (state_q == ACCESS || state_q == VERIFY) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    // Request capture and response data; word_rw/word_din only move on edges where word_sel is or becomes zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            rw_q    <= RW_READ;
            din_q   <= 4'h0;
            rdata_q <= 4'h0;
`ifdef MEM_CTRL_READBACK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wr_q    <= req_write;
                rw_q    <= req_write ? RW_WRITE : RW_READ;
                din_q   <= req_wdata;
                rdata_q <= 4'h0;
`ifdef MEM_CTRL_READBACK_EN
                err_q   <= 1'b0;
`endif
            end
            if (acc_last && !wr_q) begin
                rdata_q <= word_dout;
            end
`ifdef MEM_CTRL_READBACK_EN
            // Flip to read on the edge that drops the select, ahead of the read-back window.
            if (acc_last && wr_q) begin
                rw_q <= RW_READ;
            end
            if (vfy_last) begin
                err_q <= (word_dout != din_q);
            end
`endif
        end
    end

    mem_addr_dec #(
        .ADDR_W (ADDR_W)
    ) u_addr_dec (
        .en   (sel_en),
        .addr (addr_q),
        .sel  (word_sel)
    );

    assign word_rw   = rw_q;
    assign word_din  = din_q;
    assign rsp_rdata = rdata_q;
`ifdef MEM_CTRL_READBACK_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
